// File: rtl/univ_counter_shifter.sv
// Universal counter / shift register with prioritised single-cycle commands and status flags.
// Optional compare/match output enabled by defining UNIV_COUNTER_MATCH_EN.
module univ_counter_shifter #(
    parameter int          WIDTH    = 32,
    parameter int unsigned STEP     = 32'd1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] CounterInData,
    input  logic             CounterInMSB,
    input  logic             CounterInLSB,
    input  logic             DoClear,
    input  logic             DoLoad,
    input  logic             DoSet,
    input  logic             DoIncrement,
    input  logic             DoDecrement,
    input  logic             DoShiftL2R,
    input  logic             DoShiftR2L,
    input  logic             DoRotL2R,
    input  logic             DoRotR2L,
`ifdef UNIV_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] CompareValue,
    output logic             Match,
`endif
    output logic [WIDTH-1:0] CounterOut,
    output logic             IsZero,
    output logic             IsMax,
    output logic             Overflow,
    output logic             Underflow,
    output logic             ShiftOut
);

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic             r_ov;
    logic             r_un;
    logic             r_so;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next;
    logic             w_ov;
    logic             w_un;
    logic             w_so;

    // Next-state selection; the if/else chain encodes command priority.
    always_comb begin
        w_sum  = {1'b0, r_cnt} + {1'b0, STEP_W};
        w_diff = {1'b0, r_cnt} - {1'b0, STEP_W};
        w_next = r_cnt;
        w_ov   = 1'b0;
        w_un   = 1'b0;
        w_so   = r_so;
        if (DoClear) begin
            w_next = '0;
            w_so   = 1'b0;
        end else if (DoLoad) begin
            w_next = CounterInData;
        end else if (DoSet) begin
            w_next = ALL_ONES;
        end else if (DoIncrement) begin
            // A carry out of WIDTH bits is exactly the "Out > MAX-STEP" clamp condition.
            w_ov = w_sum[WIDTH];
            if (SATURATE && w_sum[WIDTH]) begin
                w_next = ALL_ONES;
            end else begin
                w_next = w_sum[WIDTH-1:0];
            end
        end else if (DoDecrement) begin
            w_un = w_diff[WIDTH];
            if (SATURATE && w_diff[WIDTH]) begin
                w_next = '0;
            end else begin
                w_next = w_diff[WIDTH-1:0];
            end
        end else if (DoShiftL2R) begin
            w_next = {CounterInMSB, r_cnt[WIDTH-1:1]};
            w_so   = r_cnt[0];
        end else if (DoShiftR2L) begin
            w_next = {r_cnt[WIDTH-2:0], CounterInLSB};
            w_so   = r_cnt[WIDTH-1];
        end else if (DoRotL2R) begin
            w_next = {r_cnt[0], r_cnt[WIDTH-1:1]};
            w_so   = r_cnt[0];
        end else if (DoRotR2L) begin
            w_next = {r_cnt[WIDTH-2:0], r_cnt[WIDTH-1]};
            w_so   = r_cnt[WIDTH-1];
        end else begin
            w_next = r_cnt;
        end
    end

    // State and flag registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
            r_ov  <= 1'b0;
            r_un  <= 1'b0;
            r_so  <= 1'b0;
        end else begin
            r_cnt <= w_next;
            r_ov  <= w_ov;
            r_un  <= w_un;
            r_so  <= w_so;
        end
    end

`ifdef UNIV_COUNTER_MATCH_EN
    logic r_match;

    // Match follows the registered counter value one edge later.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (r_cnt == CompareValue);
        end
    end

    assign Match = r_match;
`endif

    assign CounterOut = r_cnt;
    assign IsZero     = (r_cnt == '0);
    assign IsMax      = (r_cnt == ALL_ONES);
    assign Overflow   = r_ov;
    assign Underflow  = r_un;
    assign ShiftOut   = r_so;

endmodule

// File: tb/tb_univ_counter_shifter.sv
// Directed bench for univ_counter_shifter: three 8-bit instances (wrap/step1, saturate/step1, saturate/step3).
// Define UNIV_COUNTER_MATCH_EN to also exercise the compare/match output.
module tb_univ_counter_shifter;

    typedef struct packed {
        logic       clr, ld, set, inc, dec, sl, sr, rl, rr;
        logic       msb, lsb;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        cmd_t       c;
        logic [7:0] o;
        logic       ov, un, so;
        string      name;
    } vec_t;

    localparam logic [8:0] OP_CLR = 9'b1_0000_0000;
    localparam logic [8:0] OP_LD  = 9'b0_1000_0000;
    localparam logic [8:0] OP_SET = 9'b0_0100_0000;
    localparam logic [8:0] OP_INC = 9'b0_0010_0000;
    localparam logic [8:0] OP_DEC = 9'b0_0001_0000;
    localparam logic [8:0] OP_SL  = 9'b0_0000_1000;
    localparam logic [8:0] OP_SR  = 9'b0_0000_0100;
    localparam logic [8:0] OP_RL  = 9'b0_0000_0010;
    localparam logic [8:0] OP_RR  = 9'b0_0000_0001;
    localparam logic [8:0] OP_NONE = 9'b0_0000_0000;

    logic clk;
    logic rst_n;
    cmd_t cmd_a, cmd_b, cmd_c;
    logic [7:0] out_a, out_b, out_c;
    logic zero_a, max_a, ov_a, un_a, so_a;
    logic zero_b, max_b, ov_b, un_b, so_b;
    logic zero_c, max_c, ov_c, un_c, so_c;
`ifdef UNIV_COUNTER_MATCH_EN
    logic [7:0] cmp_a, cmp_b, cmp_c;
    logic match_a, match_b, match_c;
`endif

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs[$];

    univ_counter_shifter #(.WIDTH(8), .STEP(32'd1), .SATURATE(1'b0)) u_a (
        .Clock(clk), .nReset(rst_n), .CounterInData(cmd_a.data),
        .CounterInMSB(cmd_a.msb), .CounterInLSB(cmd_a.lsb),
        .DoClear(cmd_a.clr), .DoLoad(cmd_a.ld), .DoSet(cmd_a.set),
        .DoIncrement(cmd_a.inc), .DoDecrement(cmd_a.dec),
        .DoShiftL2R(cmd_a.sl), .DoShiftR2L(cmd_a.sr),
        .DoRotL2R(cmd_a.rl), .DoRotR2L(cmd_a.rr),
`ifdef UNIV_COUNTER_MATCH_EN
        .CompareValue(cmp_a), .Match(match_a),
`endif
        .CounterOut(out_a), .IsZero(zero_a), .IsMax(max_a),
        .Overflow(ov_a), .Underflow(un_a), .ShiftOut(so_a)
    );

    univ_counter_shifter #(.WIDTH(8), .STEP(32'd1), .SATURATE(1'b1)) u_b (
        .Clock(clk), .nReset(rst_n), .CounterInData(cmd_b.data),
        .CounterInMSB(cmd_b.msb), .CounterInLSB(cmd_b.lsb),
        .DoClear(cmd_b.clr), .DoLoad(cmd_b.ld), .DoSet(cmd_b.set),
        .DoIncrement(cmd_b.inc), .DoDecrement(cmd_b.dec),
        .DoShiftL2R(cmd_b.sl), .DoShiftR2L(cmd_b.sr),
        .DoRotL2R(cmd_b.rl), .DoRotR2L(cmd_b.rr),
`ifdef UNIV_COUNTER_MATCH_EN
        .CompareValue(cmp_b), .Match(match_b),
`endif
        .CounterOut(out_b), .IsZero(zero_b), .IsMax(max_b),
        .Overflow(ov_b), .Underflow(un_b), .ShiftOut(so_b)
    );

    univ_counter_shifter #(.WIDTH(8), .STEP(32'd3), .SATURATE(1'b1)) u_c (
        .Clock(clk), .nReset(rst_n), .CounterInData(cmd_c.data),
        .CounterInMSB(cmd_c.msb), .CounterInLSB(cmd_c.lsb),
        .DoClear(cmd_c.clr), .DoLoad(cmd_c.ld), .DoSet(cmd_c.set),
        .DoIncrement(cmd_c.inc), .DoDecrement(cmd_c.dec),
        .DoShiftL2R(cmd_c.sl), .DoShiftR2L(cmd_c.sr),
        .DoRotL2R(cmd_c.rl), .DoRotR2L(cmd_c.rr),
`ifdef UNIV_COUNTER_MATCH_EN
        .CompareValue(cmp_c), .Match(match_c),
`endif
        .CounterOut(out_c), .IsZero(zero_c), .IsMax(max_c),
        .Overflow(ov_c), .Underflow(un_c), .ShiftOut(so_c)
    );

    // Posedges at 10, 20, 30 ...; stimulus and checks happen on negedges.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic cmd_t mk(input logic [8:0] ops, input logic msb, input logic lsb,
                                input logic [7:0] data);
        return cmd_t'({ops, msb, lsb, data});
    endfunction

    function automatic void add(input cmd_t c, input logic [7:0] o, input logic ov,
                                input logic un, input logic so, input string name);
        vec_t v;
        v.c = c; v.o = o; v.ov = ov; v.un = un; v.so = so; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] model;
        int         ov_count;

        // Directed table for the wrap-mode instance, in execution order.
        add(mk(OP_LD,                  1'b0, 1'b0, 8'hA5), 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
        add(mk(OP_SL,                  1'b1, 1'b0, 8'h00), 8'hD2, 1'b0, 1'b0, 1'b1, "shl2r_msb1");
        add(mk(OP_RR,                  1'b0, 1'b0, 8'h00), 8'hA5, 1'b0, 1'b0, 1'b1, "rotr2l");
        add(mk(OP_NONE,                1'b0, 1'b0, 8'h00), 8'hA5, 1'b0, 1'b0, 1'b1, "hold");
        add(mk(OP_RL,                  1'b0, 1'b0, 8'h00), 8'hD2, 1'b0, 1'b0, 1'b1, "rotl2r");
        add(mk(OP_SR,                  1'b0, 1'b0, 8'h00), 8'hA4, 1'b0, 1'b0, 1'b1, "shr2l_lsb0");
        add(mk(OP_SL,                  1'b0, 1'b0, 8'h00), 8'h52, 1'b0, 1'b0, 1'b0, "shl2r_msb0");
        add(mk(OP_CLR | OP_LD | OP_INC, 1'b0, 1'b0, 8'h77), 8'h00, 1'b0, 1'b0, 1'b0, "clr_ld_inc");
        add(mk(OP_LD | OP_SET,         1'b0, 1'b0, 8'h3C), 8'h3C, 1'b0, 1'b0, 1'b0, "ld_set");
        add(mk(OP_INC | OP_DEC,        1'b0, 1'b0, 8'h00), 8'h3D, 1'b0, 1'b0, 1'b0, "inc_dec");
        add(mk(OP_SET,                 1'b0, 1'b0, 8'h00), 8'hFF, 1'b0, 1'b0, 1'b0, "set");
        add(mk(OP_INC,                 1'b0, 1'b0, 8'h00), 8'h00, 1'b1, 1'b0, 1'b0, "inc_wrap");
        add(mk(OP_DEC,                 1'b0, 1'b0, 8'h00), 8'hFF, 1'b0, 1'b1, 1'b0, "dec_wrap");
        add(mk(OP_NONE,                1'b0, 1'b0, 8'h00), 8'hFF, 1'b0, 1'b0, 1'b0, "un_drop");
        add(mk(OP_DEC,                 1'b0, 1'b0, 8'h00), 8'hFE, 1'b0, 1'b0, 1'b0, "dec_plain");
        add(mk(OP_SET | OP_SL,         1'b0, 1'b0, 8'h00), 8'hFF, 1'b0, 1'b0, 1'b0, "set_over_shift");
        add(mk(OP_RR,                  1'b0, 1'b0, 8'h00), 8'hFF, 1'b0, 1'b0, 1'b1, "rot_ones");
        add(mk(OP_CLR,                 1'b0, 1'b0, 8'h00), 8'h00, 1'b0, 1'b0, 1'b0, "clear");

        cmd_a = '0; cmd_b = '0; cmd_c = '0;
`ifdef UNIV_COUNTER_MATCH_EN
        cmp_a = 8'h10; cmp_b = 8'h00; cmp_c = 8'h00;
`endif

        // Reset held 25 ns with DoSet asserted: register must stay cleared.
        rst_n = 1'b0;
        cmd_a = mk(OP_SET, 1'b0, 1'b0, 8'h00);
        #24;
        chk("rst_out", out_a, 8'h00);
        chk("rst_ov", {7'd0, ov_a}, 8'h00);
        chk("rst_un", {7'd0, un_a}, 8'h00);
        chk("rst_so", {7'd0, so_a}, 8'h00);
        chk("rst_zero", {7'd0, zero_a}, 8'h01);
        #1;
        rst_n = 1'b1;
        cmd_a = '0;

        // 300 increments: Overflow pulses only on the 0xFF -> 0x00 step.
        model = 8'h00;
        ov_count = 0;
        cmd_a = mk(OP_INC, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            logic exp_ov;
            exp_ov = (model == 8'hFF);
            model  = model + 8'd1;
            tick();
            if (ov_a === 1'b1) ov_count++;
            chk("inc300_out", out_a, model);
            chk("inc300_ov", {7'd0, ov_a}, {7'd0, exp_ov});
        end
        chk("inc300_ovcount", ov_count[7:0], 8'd1);
        chk("inc300_final", out_a, 8'h2C);

        // Asynchronous reset between edges aborts the pending increment.
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out", out_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_release_inc", out_a, 8'h01);
        cmd_a = '0;

        foreach (vecs[i]) begin
            cmd_a = vecs[i].c;
            tick();
            chk({vecs[i].name, "_out"}, out_a, vecs[i].o);
            chk({vecs[i].name, "_ov"}, {7'd0, ov_a}, {7'd0, vecs[i].ov});
            chk({vecs[i].name, "_un"}, {7'd0, un_a}, {7'd0, vecs[i].un});
            chk({vecs[i].name, "_so"}, {7'd0, so_a}, {7'd0, vecs[i].so});
            chk({vecs[i].name, "_zero"}, {7'd0, zero_a}, {7'd0, vecs[i].o == 8'h00});
            chk({vecs[i].name, "_max"}, {7'd0, max_a}, {7'd0, vecs[i].o == 8'hFF});
        end
        cmd_a = '0;

        // Saturating, STEP=1: clamp at both ends.
        cmd_b = mk(OP_DEC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satb_dec0_out", out_b, 8'h00);
        chk("satb_dec0_un", {7'd0, un_b}, 8'h01);
        chk("satb_dec0_ov", {7'd0, ov_b}, 8'h00);
        cmd_b = mk(OP_LD, 1'b0, 1'b0, 8'hFE);
        tick();
        cmd_b = mk(OP_INC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satb_inc_fe_out", out_b, 8'hFF);
        chk("satb_inc_fe_ov", {7'd0, ov_b}, 8'h00);
        tick();
        chk("satb_inc_max_out", out_b, 8'hFF);
        chk("satb_inc_max_ov", {7'd0, ov_b}, 8'h01);
        cmd_b = '0;
        tick();
        chk("satb_hold_ov", {7'd0, ov_b}, 8'h00);
        chk("satb_hold_out", out_b, 8'hFF);

        // Saturating, STEP=3: clamp from 0xFD and at MAX, borrow clamp vs exact zero.
        cmd_c = mk(OP_LD, 1'b0, 1'b0, 8'hFD);
        tick();
        cmd_c = mk(OP_INC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satc_inc1_out", out_c, 8'hFF);
        chk("satc_inc1_ov", {7'd0, ov_c}, 8'h01);
        tick();
        chk("satc_inc2_out", out_c, 8'hFF);
        chk("satc_inc2_ov", {7'd0, ov_c}, 8'h01);
        cmd_c = mk(OP_LD, 1'b0, 1'b0, 8'hFB);
        tick();
        cmd_c = mk(OP_INC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satc_inc_fb_out", out_c, 8'hFE);
        chk("satc_inc_fb_ov", {7'd0, ov_c}, 8'h00);
        cmd_c = mk(OP_LD, 1'b0, 1'b0, 8'h02);
        tick();
        cmd_c = mk(OP_DEC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satc_dec2_out", out_c, 8'h00);
        chk("satc_dec2_un", {7'd0, un_c}, 8'h01);
        cmd_c = mk(OP_LD, 1'b0, 1'b0, 8'h03);
        tick();
        cmd_c = mk(OP_DEC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("satc_dec3_out", out_c, 8'h00);
        chk("satc_dec3_un", {7'd0, un_c}, 8'h00);
        cmd_c = '0;

`ifdef UNIV_COUNTER_MATCH_EN
        // Match rises the edge after CounterOut reaches 0x10, falls the edge after 0x11.
        cmd_a = mk(OP_LD, 1'b0, 1'b0, 8'h0E);
        tick();
        cmd_a = mk(OP_INC, 1'b0, 1'b0, 8'h00);
        tick();
        chk("match_0f", {7'd0, match_a}, 8'h00);
        tick();
        chk("match_at_10", {7'd0, match_a}, 8'h00);
        tick();
        chk("match_after_10", {7'd0, match_a}, 8'h01);
        chk("match_cnt_11", out_a, 8'h11);
        tick();
        chk("match_after_11", {7'd0, match_a}, 8'h00);
        cmd_a = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
